// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: transmit FSM state encoding and size defaults.
package uart_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter signals of the UART transmit FIFO, bundled with master/slave views.
interface uart_tx_fifo_if import uart_pkg::*; #(
    parameter int AW = AW_DEF
) ();

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          ovf_clr;
    logic          tx_vld;
    logic [7:0]    tx_data;
    logic          txrdy;

    modport master (
        output wr_en, wr_data, ovf_clr, txrdy,
        input  full, empty, count, ovf, tx_vld, tx_data
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, txrdy,
        output full, empty, count, ovf, tx_vld, tx_data
    );

endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping pointers, an AW+1 bit occupancy count and registered full/empty flags.
module byte_fifo import uart_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          push_ok_s, pop_ok_s;

    // Flags are judged on their registered values, so a push while full is dropped even if a pop happens too.
    always_comb begin
        push_ok_s = push_i && !full_q;
        pop_ok_s  = pop_i && !empty_q;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
        end
    end

    // Storage array, intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and hands them to a UART transmitter one start pulse at a time,
// honouring the transmitter's txrdy busy indication; also keeps a sticky overflow flag.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    tx_state_e   state_q, state_d;
    logic        tx_vld_q, tx_vld_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ovf_q, ovf_d;
    logic        pop_s;
    logic [7:0]  head_s;
    logic        full_s, empty_s;
    logic [AW:0] count_s;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_en),
        .push_data_i (bus.wr_data),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s)
    );

    // FSM state and registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tx_vld_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && bus.txrdy) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND:      state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (bus.txrdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output logic: the pop that enters SEND also loads tx_data, so the pulse carries the head byte.
    always_comb begin
        pop_s     = (state_q == ST_IDLE) && !empty_s && bus.txrdy;
        tx_vld_d  = (state_d == ST_SEND);
        tx_data_d = pop_s ? head_s : tx_data_q;
    end

    // Sticky overflow: a rejected write outranks a clear in the same cycle.
    always_comb begin
        if (bus.wr_en && full_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.full    = full_s;
    assign bus.empty   = empty_s;
    assign bus.count   = count_s;
    assign bus.ovf     = ovf_q;
    assign bus.tx_vld  = tx_vld_q;
    assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a byte scoreboard checked on every tx_vld pulse,
// a simple transmitter model driving txrdy, and flag/count checks at each step.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int AW    = AW_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int BUSY  = 4;

    logic clk = 1'b0;
    logic rst;
    logic force_busy;
    int   busy_cnt = 0;

    int n_pass    = 0;
    int n_total   = 0;
    int pulse_cnt = 0;
    int cyc       = 0;
    int last_pulse = -1000;
    int base;

    logic [7:0] exp_q [$];

    uart_tx_fifo_if #(.AW(AW)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for BUSY cycles after each start pulse, or while forced busy.
    assign bus.txrdy = !force_busy && (busy_cnt == 0);
    always @(posedge clk) begin
        if (bus.tx_vld === 1'b1) busy_cnt <= BUSY;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accepted);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accepted) exp_q.push_back(b);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int left = budget;
        while (pulse_cnt < target && left > 0) begin
            tick();
            left--;
        end
        chk("pulse_count", pulse_cnt, target);
    endtask

    // Output monitor: every pulse must carry the oldest expected byte, with txrdy high and proper spacing.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_vld === 1'b1) begin
                pulse_cnt++;
                chk("vld_while_busy", {31'd0, bus.txrdy}, 32'd1);
                chk("pulse_spacing", {31'd0, (cyc - last_pulse) >= (3 + BUSY)}, 32'd1);
                last_pulse = cyc;
                chk("scoreboard_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data_order", {24'd0, bus.tx_data}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        force_busy  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst_count",   {27'd0, bus.count}, 32'd0);
        chk("rst_empty",   {31'd0, bus.empty}, 32'd1);
        chk("rst_full",    {31'd0, bus.full}, 32'd0);
        chk("rst_ovf",     {31'd0, bus.ovf}, 32'd0);
        chk("rst_tx_vld",  {31'd0, bus.tx_vld}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        rst = 1'b1;
        tick();

        // Single byte: pulse in the cycle after the second edge.
        write_byte(8'hA5, 1'b1);
        chk("single_n_vld",   {31'd0, bus.tx_vld}, 32'd0);
        chk("single_n_empty", {31'd0, bus.empty}, 32'd0);
        chk("single_n_count", {27'd0, bus.count}, 32'd1);
        tick();
        chk("single_vld",     {31'd0, bus.tx_vld}, 32'd1);
        chk("single_data",    {24'd0, bus.tx_data}, 32'hA5);
        chk("single_empty",   {31'd0, bus.empty}, 32'd1);
        wait_pulses(1, 20);
        repeat (12) tick();

        // Burst fill with the transmitter busy, then overflow handling.
        force_busy = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
        chk("burst_full",  {31'd0, bus.full}, 32'd1);
        chk("burst_count", {27'd0, bus.count}, 32'd16);
        write_byte(8'hFF, 1'b0);
        chk("ovf_set",     {31'd0, bus.ovf}, 32'd1);
        chk("ovf_count",   {27'd0, bus.count}, 32'd16);
        tick();
        chk("ovf_sticky",  {31'd0, bus.ovf}, 32'd1);
        bus.ovf_clr = 1'b1;
        write_byte(8'hFF, 1'b0);
        bus.ovf_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, bus.ovf}, 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr",     {31'd0, bus.ovf}, 32'd0);
        force_busy = 1'b0;
        wait_pulses(17, 300);
        chk("burst_drained_empty", {31'd0, bus.empty}, 32'd1);
        repeat (12) tick();

        // Full FIFO with a pop and a write on the same edge: write rejected.
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b1);
        chk("simul_pre_count", {27'd0, bus.count}, 32'd16);
        force_busy = 1'b0;
        write_byte(8'hEE, 1'b0);
        chk("simul_count", {27'd0, bus.count}, 32'd15);
        chk("simul_ovf",   {31'd0, bus.ovf}, 32'd1);
        chk("simul_full",  {31'd0, bus.full}, 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        wait_pulses(33, 300);
        repeat (12) tick();

        // Busy hold-off: nothing leaves while txrdy stays low.
        force_busy = 1'b1;
        write_byte(8'h31, 1'b1);
        write_byte(8'h32, 1'b1);
        write_byte(8'h33, 1'b1);
        base = pulse_cnt;
        repeat (1000) tick();
        chk("holdoff_no_pulse", pulse_cnt, base);
        chk("holdoff_count",    {27'd0, bus.count}, 32'd3);
        force_busy = 1'b0;
        repeat (3) tick();
        chk("holdoff_one_pulse", pulse_cnt, base + 1);
        wait_pulses(base + 3, 60);
        repeat (12) tick();

        // Reset mid-stream discards queued bytes.
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h41 + 8'(i), 1'b1);
        chk("midrst_pre_count", {27'd0, bus.count}, 32'd5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        chk("midrst_count",  {27'd0, bus.count}, 32'd0);
        chk("midrst_empty",  {31'd0, bus.empty}, 32'd1);
        chk("midrst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
        force_busy = 1'b0;
        base = pulse_cnt;
        repeat (50) tick();
        chk("midrst_no_pulse", pulse_cnt, base);
        write_byte(8'h77, 1'b1);
        tick();
        chk("post_rst_vld",  {31'd0, bus.tx_vld}, 32'd1);
        chk("post_rst_data", {24'd0, bus.tx_data}, 32'h77);
        wait_pulses(base + 1, 20);
        repeat (12) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; SHALL be a power of two, 4 to 256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; SHALL be sampled only on a rising clk edge.
REQ-005 wr_en  input  1  producer write strobe; SHALL request one byte per cycle while high.
REQ-006 wr_data  input  8  byte to enqueue; SHALL be sampled when wr_en=1.
REQ-007 full  output  1  SHALL be 1 when count==DEPTH.
REQ-008 empty  output  1  SHALL be 1 when count==0.
REQ-009 count  output  AW+1  number of bytes held in the FIFO.
REQ-010 ovf  output  1  sticky flag; SHALL be set by a write rejected while full.
REQ-011 ovf_clr  input  1  SHALL clear ovf.
REQ-012 tx_vld  output  1  one-cycle start pulse to the UART transmitter.
REQ-013 tx_data  output  8  byte presented with tx_vld; SHALL be held stable until the next pulse.
REQ-014 txrdy  input  1  transmitter idle; a frame in progress SHALL be indicated by txrdy=0.

Function
REQ-015 Writes: a write SHALL be accepted when wr_en=1 and full=0.
REQ-016 A write SHALL be rejected when full=1, even if a pop occurs in the same cycle.
REQ-017 A rejected write SHALL leave the FIFO contents unchanged and set ovf on the next edge.
REQ-018 Ordering: bytes SHALL leave in write order; pointers SHALL wrap modulo DEPTH.
REQ-019 Concurrent write and pop with full=0: count SHALL be unchanged and both operations SHALL complete.
REQ-020 ovf priority: set SHALL win over ovf_clr in the same cycle.
REQ-021 FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE -> SEND when empty=0 and txrdy=1; on that edge the head byte SHALL be popped into tx_data.
REQ-023 SEND: tx_vld=1 for exactly one cycle; the FSM SHALL then go unconditionally to WAIT_BUSY.
REQ-024 WAIT_BUSY: lasts exactly one cycle, giving the transmitter time to drop txrdy; the FSM SHALL then go to WAIT_DONE.
REQ-025 WAIT_DONE: the FSM SHALL stay while txrdy=0 and go to IDLE when txrdy=1.
REQ-026 tx_vld SHALL be 0 in every state other than SEND, so a start pulse is never issued while txrdy=0.
REQ-027 Latency: a write accepted at edge N into an empty FIFO, with the FSM in IDLE and txrdy=1, SHALL give tx_vld=1 in the cycle following edge N+1.
REQ-028 Spacing: consecutive tx_vld pulses SHALL be separated by at least 3 cycles plus the txrdy-low interval.
REQ-029 full, empty and count SHALL be registered and SHALL reflect all writes and pops of the previous edge.
REQ-030 count arithmetic SHALL be AW+1 bits wide, with no wrap; count==DEPTH SHALL be representable.

Reset
REQ-031 While rst=0 at an edge, the following SHALL be forced:
  - FSM to IDLE;
  - pointers to 0 and count to 0;
  - empty=1, full=0, ovf=0;
  - tx_vld=0, tx_data=8'h00.
REQ-032 Reset mid-operation SHALL discard all buffered bytes; a frame already started in the transmitter is not aborted by this block.
REQ-033 Storage array contents SHALL NOT require reset.

Structure
REQ-034 The shared package uart_pkg SHALL hold the FSM state enum and the DEPTH/AW defaults.
REQ-035 Storage SHALL be one sub-module, byte_fifo (pointers, count, flags and memory); the top SHALL hold the FSM, tx_data register and ovf.
REQ-036 The block SHALL connect directly to the transmitter ports tx_vld, tx_data and txrdy with no glue logic.

Verification
REQ-037 Single byte: write 8'hA5 with txrdy=1 -> tx_vld pulse 2 cycles later, tx_data=8'hA5, empty=1 afterwards.
REQ-038 Burst: write 8'h01 to 8'h10 (16 bytes) back-to-back -> full=1 after the 16th write; bytes leave in order 8'h01 to 8'h10, one per txrdy 1->0->1 cycle.
REQ-039 Overflow: fill to 16, then write 8'hFF -> ovf=1 and count stays 16; 8'hFF is never transmitted; ovf_clr -> ovf=0.
REQ-040 Busy hold-off: keep txrdy=0 for 1000 cycles with 3 bytes queued -> no tx_vld pulse; txrdy=1 -> exactly one pulse, then wait for the next busy/idle cycle.
REQ-041 Simultaneous: count=16 with a pop and a write in the same cycle -> write rejected, ovf=1, count=15.
REQ-042 Reset mid-stream: 5 bytes queued, rst=0 for 1 cycle -> count=0, empty=1, tx_vld=0, FSM in IDLE; no further pulses.
